// File: rtl/usb_boot_pkg.sv
// usb_boot_pkg: shared definitions for the USB boot supervisor.
//   boot_state_t : supervisor state encoding (IDLE, CONNECTED, ARMED, BOOT)
//   IMG_W        : width of the SB_WARMBOOT image index
//   PWM_W        : width of the LED PWM counter
//   PWM_DUTY     : LED on-time in PWM counts (4/256 = 1/64 duty)
package usb_boot_pkg;

    localparam int IMG_W    = 2;
    localparam int PWM_W    = 8;
    localparam int PWM_DUTY = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CONNECTED = 2'd1,
        ST_ARMED     = 2'd2,
        ST_BOOT      = 2'd3
    } boot_state_t;

endpackage

// File: rtl/usb_boot_supervisor_if.sv
// usb_boot_supervisor_if: request-side bus of the boot supervisor.
//   sof_valid   : single-cycle SOF strobe from the USB protocol engine
//   boot_req    : single-cycle user boot request
//   boot_image  : image index qualified by boot_req
//   invalid_req : one-cycle pulse when a boot_req names a missing image
// Modports: master (request source), slave (supervisor).
interface usb_boot_supervisor_if;
    import usb_boot_pkg::*;

    logic             sof_valid;
    logic             boot_req;
    logic [IMG_W-1:0] boot_image;
    logic             invalid_req;

    modport master (output sof_valid, boot_req, boot_image, input invalid_req);
    modport slave  (input sof_valid, boot_req, boot_image, output invalid_req);

endinterface

// File: rtl/usb_boot_supervisor_led.sv
// boot_status_led: status LED driver for the boot supervisor.
//   clk, reset : system clock, asynchronous active-high reset
//   state      : current supervisor state
//   led_rgb    : PWM drive {blue, green, red} for SB_RGBA_DRV
// IDLE blinks red at 2 Hz, CONNECTED shows steady green, ARMED/BOOT steady blue.
// All colours are dimmed by an 8-bit PWM at 1/64 duty.
module boot_status_led
    import usb_boot_pkg::*;
#(
    parameter int CLK_HZ = 48000000
) (
    input  logic        clk,
    input  logic        reset,
    input  boot_state_t state,
    output logic [2:0]  led_rgb
);

    // Blink toggles every quarter second, giving a 2 Hz on/off period.
    localparam int HALF  = CLK_HZ / 4;
    localparam int BLK_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(HALF - 1);

    logic [PWM_W-1:0] pwm_cnt;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink;
    logic             pwm_on;

    assign pwm_on = (pwm_cnt < PWM_W'(PWM_DUTY));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            blink     <= 1'b0;
            led_rgb   <= 3'b000;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (blink_cnt == BLK_LAST) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            case (state)
                ST_IDLE:      led_rgb <= {1'b0, 1'b0, pwm_on & blink};
                ST_CONNECTED: led_rgb <= {1'b0, pwm_on, 1'b0};
                default:      led_rgb <= {pwm_on, 1'b0, 1'b0};
            endcase
        end
    end

endmodule

// File: rtl/usb_boot_supervisor.sv
// usb_boot_supervisor: picks an iCE40 warmboot image and fires SB_WARMBOOT.
// Boots DEFAULT_IMAGE when no SOF arrives for TIMEOUT_MS, or the image named
// by a user boot_req. The selected image is held on warmboot_sel for
// SETUP_CYCLES before warmboot_boot rises; BOOT is terminal until reset.
// Ports:
//   clk           : system clock (single clock domain)
//   reset         : asynchronous active-high reset
//   bus           : usb_boot_supervisor_if.slave (sof_valid, boot_req,
//                   boot_image in; invalid_req out)
//   warmboot_sel  : SB_WARMBOOT {S1,S0}
//   warmboot_boot : SB_WARMBOOT BOOT
//   host_present  : high while CONNECTED
//   led_rgb       : {blue, green, red} status PWM
// Build option: define BOOT_SUPERVISOR_LED_EN to include the status LED
// driver; otherwise led_rgb is tied low.
module usb_boot_supervisor
    import usb_boot_pkg::*;
#(
    parameter int CLK_HZ          = 48000000,
    parameter int TIMEOUT_MS      = 1000,
    parameter int NUM_IMAGES      = 4,
    parameter int DEFAULT_IMAGE   = 1,
    parameter int SETUP_CYCLES    = 16,
    parameter int STAY_AFTER_ENUM = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    usb_boot_supervisor_if.slave     bus,
    output logic [IMG_W-1:0]         warmboot_sel,
    output logic                     warmboot_boot,
    output logic                     host_present,
    output logic [2:0]               led_rgb
);

    localparam int TC_VAL = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int TMR_W  = $clog2(TC_VAL + 1);
    localparam logic [TMR_W-1:0] TC    = TMR_W'(TC_VAL);
    localparam logic [TMR_W-1:0] TC_M1 = TMR_W'(TC_VAL - 1);
    localparam int SET_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETUP_CYCLES - 1);
    localparam logic [IMG_W-1:0] DEF_IMG  = IMG_W'(DEFAULT_IMAGE);

    boot_state_t      state;
    logic [TMR_W-1:0] timer;
    logic [SET_W-1:0] setup_cnt;
    logic             listening;
    logic             img_ok;
    logic             req_ok;
    logic             req_bad;
    logic             tc_hit;
    logic             tc_arms;

    assign listening = (state == ST_IDLE) || (state == ST_CONNECTED);
    assign img_ok    = (int'(bus.boot_image) < NUM_IMAGES);
    assign req_ok    = listening && bus.boot_req && img_ok;
    assign req_bad   = listening && bus.boot_req && !img_ok;

    // The timeout fires on the edge where the timer steps onto TC. A SOF in
    // the same cycle clears the timer instead, so it always wins. Once the
    // timer has saturated it cannot fire again until a SOF clears it, which
    // is what disables the timeout after a STAY_AFTER_ENUM drop to IDLE.
    assign tc_hit  = !bus.sof_valid && (timer == TC_M1);
    assign tc_arms = tc_hit && !((state == ST_CONNECTED) && (STAY_AFTER_ENUM != 0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (bus.sof_valid) begin
            timer <= '0;
        end else if (timer != TC) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            setup_cnt       <= '0;
            warmboot_sel    <= '0;
            warmboot_boot   <= 1'b0;
            host_present    <= 1'b0;
            bus.invalid_req <= 1'b0;
        end else begin
            bus.invalid_req <= req_bad;
            case (state)
                ST_IDLE, ST_CONNECTED: begin
                    // A valid request beats both the timeout and a SOF.
                    if (req_ok || tc_arms) begin
                        state        <= ST_ARMED;
                        warmboot_sel <= req_ok ? bus.boot_image : DEF_IMG;
                        setup_cnt    <= '0;
                        host_present <= 1'b0;
                    end else if (bus.sof_valid) begin
                        state        <= ST_CONNECTED;
                        host_present <= 1'b1;
                    end else if (tc_hit) begin
                        state        <= ST_IDLE;
                        host_present <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (setup_cnt == SET_LAST) begin
                        state         <= ST_BOOT;
                        warmboot_boot <= 1'b1;
                    end else begin
                        setup_cnt <= setup_cnt + 1'b1;
                    end
                end
                ST_BOOT: begin
                    warmboot_boot <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BOOT_SUPERVISOR_LED_EN
    boot_status_led #(
        .CLK_HZ (CLK_HZ)
    ) u_led (
        .clk     (clk),
        .reset   (reset),
        .state   (state),
        .led_rgb (led_rgb)
    );
`else
    assign led_rgb = 3'b000;
`endif

endmodule
